// File: rtl/data_mem_responder.sv
// Purpose : responder for the CPU data-RAM port. It owns the byte memory, serves CPU reads and
//           writes, and sequences a host session: header (N lo/hi), load N bytes, run the CPU,
//           then dump min(N,DEPTH) bytes.
// Latency : cpu_dout is combinational. Host input bytes are taken on the accepting edge. The first
//           dump byte is valid in the first DUMP cycle, and each later byte follows its acceptance by one cycle.
// Backpressure: host_in_ready is high in HDR_LO/HDR_HI/LOAD. host_out_data is held while valid & !ready.
// Ports   : clk/reset (async active-low); cpu_* CPU data port plus run enable and finish;
//           host_in_* 8-bit valid/ready load stream; host_out_* 8-bit valid/ready dump stream;
//           state exposes the sequencer state (0 HDR_LO .. 4 DUMP).
module data_mem_responder #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   input  logic              cpu_finish,
   output logic              cpu_enable,
   input  logic              host_in_valid,
   input  logic [7:0]        host_in_data,
   output logic              host_in_ready,
   output logic              host_out_valid,
   output logic [7:0]        host_out_data,
   input  logic              host_out_ready,
   output logic [2:0]        state
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [16:0]     DEPTH_N = 17'(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

   localparam logic [2:0] HDR_LO = 3'd0;
   localparam logic [2:0] HDR_HI = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] DUMP   = 3'd4;

   logic [2:0]  r_state;
   logic [15:0] r_n;
   logic [15:0] r_ptr;
   logic        r_cpu_enable;
   logic        r_out_vld;
   logic [7:0]  r_out_dat;
   logic [7:0]  r_mem [DEPTH];

   logic             w_in_acc;
   logic             w_out_acc;
   logic             w_cpu_hit;
   logic             w_cpu_wr;
   logic [IDX_W-1:0] w_cpu_idx;
   logic [16:0]      w_m;
   logic [16:0]      w_ptr_inc;
   logic             w_load_hit;
   logic             w_mem_we;
   logic [IDX_W-1:0] w_mem_idx;
   logic [7:0]       w_mem_wdat;
   logic [IDX_W-1:0] w_rd_idx;
   logic [7:0]       w_dump_dat;
   logic [2:0]       w_state_nxt;

   assign host_in_ready  = (r_state == HDR_LO) || (r_state == HDR_HI) || (r_state == LOAD);
   assign w_in_acc       = host_in_valid & host_in_ready;
   assign w_out_acc      = r_out_vld & host_out_ready;
   assign w_cpu_hit      = ({1'b0, cpu_addr} < DEPTH_A);
   assign w_cpu_wr       = (r_state == RUN) & cpu_we & w_cpu_hit;
   assign w_cpu_idx      = cpu_addr[IDX_W-1:0];
   assign w_m            = ({1'b0, r_n} > DEPTH_N) ? DEPTH_N : {1'b0, r_n};
   // 17 bits so "pointer + 1" can be compared against N or M up to 65535/65536 without wrapping
   assign w_ptr_inc      = {1'b0, r_ptr} + 17'd1;
   assign w_load_hit     = ({1'b0, r_ptr} < DEPTH_N);

   assign cpu_dout       = w_cpu_hit ? r_mem[w_cpu_idx] : 8'h00;
   assign cpu_enable     = r_cpu_enable;
   assign host_out_valid = r_out_vld;
   assign host_out_data  = r_out_dat;
   assign state          = r_state;

   // Single write port. Load writes and CPU writes are exclusive by state.
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_idx  = w_cpu_idx;
      w_mem_wdat = cpu_din;
      if ((r_state == LOAD) && w_in_acc && w_load_hit) begin
         w_mem_we   = 1'b1;
         w_mem_idx  = r_ptr[IDX_W-1:0];
         w_mem_wdat = host_in_data;
      end else if (w_cpu_wr) begin
         w_mem_we   = 1'b1;
      end
   end

   // The dump prefetch reads byte 0 on the RUN->DUMP edge and byte ptr+1 afterwards.
   // A CPU write landing on that same edge is forwarded so the dump sees the final memory.
   assign w_rd_idx   = (r_state == RUN) ? '0 : w_ptr_inc[IDX_W-1:0];
   assign w_dump_dat = (w_mem_we && (w_mem_idx == w_rd_idx)) ? w_mem_wdat : r_mem[w_rd_idx];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HDR_LO: if (w_in_acc) w_state_nxt = HDR_HI;
         HDR_HI: if (w_in_acc) w_state_nxt = ({host_in_data, r_n[7:0]} == 16'd0) ? RUN : LOAD;
         LOAD:   if (w_in_acc && (w_ptr_inc == {1'b0, r_n})) w_state_nxt = RUN;
         RUN:    if (cpu_finish) w_state_nxt = DUMP;
         // In DUMP, valid is low only when M==0, because the last acceptance leaves DUMP on the same edge.
         DUMP:   if (!r_out_vld || (w_out_acc && (w_ptr_inc == w_m))) w_state_nxt = HDR_LO;
         default: w_state_nxt = HDR_LO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= HDR_LO;
         r_n          <= 16'd0;
         r_ptr        <= 16'd0;
         r_cpu_enable <= 1'b0;
         r_out_vld    <= 1'b0;
         r_out_dat    <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_cpu_enable <= (w_state_nxt == RUN);
         case (r_state)
            HDR_LO: if (w_in_acc) r_n[7:0] <= host_in_data;
            HDR_HI: if (w_in_acc) begin
               r_n[15:8] <= host_in_data;
               r_ptr     <= 16'd0;
            end
            LOAD:   if (w_in_acc) r_ptr <= w_ptr_inc[15:0];
            RUN:    if (cpu_finish) begin
               r_ptr <= 16'd0;
               if (w_m != 17'd0) begin
                  r_out_vld <= 1'b1;
                  r_out_dat <= w_dump_dat;
               end
            end
            DUMP:   if (w_out_acc) begin
               if (w_ptr_inc == w_m) begin
                  r_out_vld <= 1'b0;
               end else begin
                  r_ptr     <= w_ptr_inc[15:0];
                  r_out_dat <= w_dump_dat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
